// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the spi_flash Wishbone bridge.
//   bridge_state_t : bridge FSM states
//   WORD_BYTES     : bytes per flash word fetched by the bridge
package spi_flash_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    PF_ISSUE = 2'd2,
    PF_WAIT  = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/spi_flash_wb_bridge_if.sv
// Wishbone-classic bus bundle between a bus master and spi_flash_wb_bridge.
//   slave modport  : the bridge (samples cyc/stb/we/adr, drives dat/ack)
//   master modport : the requester
interface spi_flash_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 24
);

  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_o;

  modport slave (
    input  wb_cyc_i,
    input  wb_stb_i,
    input  wb_we_i,
    input  wb_adr_i,
    output wb_dat_o,
    output wb_ack_o
  );

  modport master (
    output wb_cyc_i,
    output wb_stb_i,
    output wb_we_i,
    output wb_adr_i,
    input  wb_dat_o,
    input  wb_ack_o
  );

endinterface

// File: rtl/spi_flash_wb_bridge.sv
// Read-only Wishbone-classic slave in front of spi_flash.
// Bus reads become single-word flash_strobe/flash_done transactions. A one-word buffer
// serves repeat reads, and (PREFETCH_EN) the next sequential word is fetched after every
// demand fill so linear fetch hits the controller's continuous-read path.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   wb                 : Wishbone slave bundle (cyc/stb/we/adr in, dat/ack out)
//   flash_addr         : word-aligned address to spi_flash, held until flash_done
//   flash_strobe       : one-cycle transaction start
//   flash_data         : spi_flash read word
//   flash_done         : spi_flash completion pulse
//   flash_initialized  : spi_flash init complete; requests stall until set
module spi_flash_wb_bridge
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_wb_bridge_if.slave  wb,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  output logic                  flash_strobe,
  input  logic [31:0]           flash_data,
  input  logic                  flash_done,
  input  logic                  flash_initialized
);

  localparam int unsigned WA = ADDR_WIDTH - 2;

  bridge_state_t   state_q, state_d;
  logic            buf_valid_q, buf_valid_d;
  logic [WA-1:0]   buf_addr_q, buf_addr_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [ADDR_WIDTH-1:0] flash_addr_q, flash_addr_d;
  logic            strobe_q, strobe_d;

  logic            req;
  logic [WA-1:0]   adr_w;
  logic [WA-1:0]   faddr_w;
  logic            hit;
  logic            top_word;
  logic [WA-1:0]   pf_w;
  logic            unused_adr_lsb;

  // Byte-lane bits carry no information for a word-wide read-only slave.
  assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

  // Masking with ack_q keeps a classic master that still holds stb in the ack cycle
  // from being seen as a second request.
  assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & flash_initialized;
  assign adr_w    = wb.wb_adr_i[ADDR_WIDTH-1:2];
  assign faddr_w  = flash_addr_q[ADDR_WIDTH-1:2];
  assign hit      = buf_valid_q && (buf_addr_q == adr_w);
  assign top_word = &faddr_w;
  assign pf_w     = buf_addr_q + WA'(1);

  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    ack_d        = 1'b0;
    dat_d        = dat_q;
    flash_addr_d = flash_addr_q;
    strobe_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (wb.wb_we_i) begin
            ack_d = 1'b1;
            dat_d = 32'h0;
          end else if (hit) begin
            ack_d = 1'b1;
            dat_d = buf_data_q;
          end else begin
            strobe_d     = 1'b1;
            flash_addr_d = {adr_w, 2'b00};
            state_d      = FETCH;
          end
        end
      end

      FETCH: begin
        // The fill completes even if the master walked away; ack only a request that is
        // still the one being fetched. Anything else is re-evaluated from IDLE.
        if (flash_done) begin
          buf_data_d  = flash_data;
          buf_addr_d  = faddr_w;
          buf_valid_d = 1'b1;
          if (wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_we_i && (adr_w == faddr_w)) begin
            ack_d = 1'b1;
            dat_d = flash_data;
          end
          state_d = (PREFETCH_EN && !top_word) ? PF_ISSUE : IDLE;
        end
      end

      PF_ISSUE: begin
        strobe_d     = 1'b1;
        flash_addr_d = {pf_w, 2'b00};
        state_d      = PF_WAIT;
      end

      PF_WAIT: begin
        // Requests are held until the prefetch lands; only a read of the prefetched word
        // is answered directly, the rest see the refreshed buffer from IDLE.
        if (flash_done) begin
          buf_data_d = flash_data;
          buf_addr_d = faddr_w;
          if (req && !wb.wb_we_i && (adr_w == faddr_w)) begin
            ack_d = 1'b1;
            dat_d = flash_data;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      flash_addr_q <= '0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      flash_addr_q <= flash_addr_d;
      strobe_q     <= strobe_d;
    end
  end

  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_dat_o  = dat_q;
  assign flash_addr   = flash_addr_q;
  assign flash_strobe = strobe_q;

endmodule

// File: tb/tb_spi_flash_wb_bridge.sv
// Bench for spi_flash_wb_bridge: directed scenarios plus randomized bus traffic against a
// behavioural flash model. Read data is checked by a scoreboard monitor on every ack.
module tb_spi_flash_wb_bridge;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] flash_addr;
  logic          flash_strobe;
  logic [31:0]   flash_data = 32'h0;
  logic          flash_done = 1'b0;
  logic          flash_initialized;

  spi_flash_wb_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  spi_flash_wb_bridge #(
    .ADDR_WIDTH (AW),
    .PREFETCH_EN(1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb               (bus),
    .flash_addr       (flash_addr),
    .flash_strobe     (flash_strobe),
    .flash_data       (flash_data),
    .flash_done       (flash_done),
    .flash_initialized(flash_initialized)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents: the word at 0x100 is fixed, everything else is an address hash.
  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    if (a == 24'h000100) return 32'hDEADBEEF;
    return {a[23:2], 2'b00, 8'h3C} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- flash controller model ----------------
  bit            busy = 1'b0;
  int            lat_left = 0;
  logic [AW-1:0] paddr = '0;
  int            n_strobe = 0;
  logic [AW-1:0] strb_q[$];
  int            last_done_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      busy       = 1'b0;
      flash_done = 1'b0;
    end else begin
      flash_done = 1'b0;
      if (flash_strobe) begin
        chk("strobe_while_busy", 32'(busy), 32'd0);
        busy     = 1'b1;
        paddr    = flash_addr;
        lat_left = $urandom_range(2, 6);
        n_strobe++;
        strb_q.push_back(flash_addr);
      end else if (busy) begin
        lat_left--;
        if (lat_left == 0) begin
          chk("flash_addr_held", 32'(flash_addr), 32'(paddr));
          flash_done    = 1'b1;
          flash_data    = mem(paddr);
          busy          = 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic          we;
    logic [31:0]   d;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_acks = 0;

  always @(negedge clk) begin
    if (!reset && bus.wb_ack_o) begin
      n_acks++;
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL spurious_ack: got ack with dat %h, want no ack (cycle %0d)",
                 bus.wb_dat_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.we) chk("rd_data", bus.wb_dat_o, mon_e.d);
      end
    end
  end

  // ---------------- bus master ----------------
  // Called right after a negedge; returns ack latency in cycles and the ack cycle.
  task automatic do_req(input logic we, input logic [AW-1:0] a, output int lat,
                        output int ackc);
    exp_t e;
    int   start;
    bit   got;
    e.we = we;
    e.a  = a;
    e.d  = we ? 32'h0 : mem({a[23:2], 2'b00});
    exp_q.push_back(e);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = a;
    start = cyc;
    got   = 1'b0;
    lat   = -1;
    ackc  = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        got  = 1'b1;
        lat  = cyc - start;
        ackc = cyc;
        break;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'd0);
    chk({tag, "_dat"}, bus.wb_dat_o, 32'd0);
    chk({tag, "_strobe"}, 32'(flash_strobe), 32'd0);
    chk({tag, "_faddr"}, 32'(flash_addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int            lat, ackc, s0;
    logic [AW-1:0] a, prev;
    logic          we;
    bit            seen;

    reset             = 1'b1;
    flash_initialized = 1'b0;
    bus.wb_cyc_i      = 1'b0;
    bus.wb_stb_i      = 1'b0;
    bus.wb_we_i       = 1'b0;
    bus.wb_adr_i      = '0;
    idle(3);
    chk_reset_outputs("rst");
    reset = 1'b0;
    idle(2);

    // Read before init stalls, then completes once init rises.
    fork
      do_req(1'b0, 24'h000100, lat, ackc);
      begin
        idle(20);
        chk("no_ack_before_init", 32'(n_acks), 32'd0);
        chk("no_strobe_before_init", 32'(n_strobe), 32'd0);
        flash_initialized = 1'b1;
      end
    join
    chk("strobe0_addr", 32'(strb_q[0]), 32'h000100);

    // Prefetched word requested while its fetch is in flight.
    do_req(1'b0, 24'h000104, lat, ackc);
    chk("pf_ack_after_done", 32'(ackc - last_done_cyc), 32'd1);
    chk("pf_strobe_count", 32'(n_strobe), 32'd2);
    chk("pf_strobe_addr", 32'(strb_q[1]), 32'h000104);
    idle(3);
    chk("no_extra_strobe", 32'(n_strobe), 32'd2);

    // Repeat read of buffered word: one-cycle hit.
    do_req(1'b0, 24'h000106, lat, ackc);
    chk("hit_latency", 32'(lat), 32'd1);
    chk("hit_no_strobe", 32'(n_strobe), 32'd2);

    // Unrelated read during prefetch waits for it, then fetches on demand.
    do_req(1'b0, 24'h000300, lat, ackc);
    do_req(1'b0, 24'h000200, lat, ackc);
    chk("held_strobe_count", 32'(n_strobe), 32'd5);
    chk("held_strobe_pf", 32'(strb_q[3]), 32'h000304);
    chk("held_strobe_demand", 32'(strb_q[4]), 32'h000200);
    idle(30);
    chk("held_then_pf_count", 32'(n_strobe), 32'd6);
    chk("held_then_pf_addr", 32'(strb_q[5]), 32'h000204);
    do_req(1'b0, 24'h000204, lat, ackc);
    chk("pf_hit_latency", 32'(lat), 32'd1);

    // Top word: demand fetch only.
    s0 = n_strobe;
    do_req(1'b0, 24'hFFFFFF, lat, ackc);
    idle(30);
    chk("top_no_prefetch", 32'(n_strobe - s0), 32'd1);
    chk("top_strobe_addr", 32'(strb_q[s0]), 32'hFFFFFC);

    // Writes ack in one cycle with no flash traffic.
    s0 = n_strobe;
    do_req(1'b1, 24'h123454, lat, ackc);
    chk("write_latency", 32'(lat), 32'd1);
    chk("write_no_strobe", 32'(n_strobe - s0), 32'd0);

    // Master drops the cycle mid-fetch: fill and prefetch still happen, no ack.
    s0 = n_strobe;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 24'h000500;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(1);
      seen = (n_strobe > s0);
    end
    chk("abort_strobe_seen", 32'(seen), 32'd1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    idle(30);
    chk("abort_fill_and_pf", 32'(n_strobe - s0), 32'd2);
    do_req(1'b0, 24'h000504, lat, ackc);
    chk("abort_pf_hit", 32'(lat), 32'd1);

    // Reset while in FETCH clears outputs and the buffer.
    s0 = n_strobe;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 24'h000600;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(1);
      seen = (n_strobe > s0);
    end
    reset        = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    idle(1);
    chk_reset_outputs("midrst");
    reset = 1'b0;
    idle(2);
    s0 = n_strobe;
    do_req(1'b0, 24'h000504, lat, ackc);
    chk("postrst_miss", 32'(n_strobe > s0), 32'd1);
    chk("postrst_miss_addr", 32'(strb_q[s0]), 32'h000504);
    idle(30);

    // Randomized traffic, biased toward sequential fetch.
    prev = 24'h000800;
    for (int n = 0; n < 200; n++) begin
      int r;
      r  = $urandom_range(0, 99);
      we = ($urandom_range(0, 99) < 15);
      if (r < 60)      a = prev + 24'd4;
      else if (r < 80) a = prev;
      else             a = 24'($urandom_range(0, 1023)) << 2;
      a[1:0] = 2'($urandom_range(0, 3));
      if (!we) prev = {a[23:2], 2'b00};
      do_req(we, a, lat, ackc);
      idle($urandom_range(0, 3));
    end

    idle(30);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
